audio_source_arbiter: RTL

Schedules up to NUM_SRC stereo sample producers onto the single 44.1 kHz delta-sigma audio output. It sits in the clk_audio domain between the producers (tone generators, sample players, test patterns) and the audio output block's ready/wreq/sample port. It grants the output to one source at a time, round-robin, for bursts of up to BURST_LEN samples. It also generates the one-cycle write request each time the output block signals ready.

---
 rtl/audio_pkg.sv | 24 ++
 rtl/audio_source_arbiter_if.sv | 35 +++
 rtl/audio_rr_pick.sv | 39 +++
 rtl/audio_source_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the audio output arbitration logic.
//   arb_state_t        : arbiter state encoding (IDLE / OWN / WAIT_LOW)
//   AUDIO_BITS_DEFAULT : default bits per audio channel
//   UNDERRUN_W         : width of the optional underrun counter
//   idx_width()        : width of an index able to address n sources
// -----------------------------------------------------------------------------
package audio_pkg;

   localparam int AUDIO_BITS_DEFAULT = 12;
   localparam int UNDERRUN_W         = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      OWN      = 2'd1,
      WAIT_LOW = 2'd2
   } arb_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/audio_source_arbiter_if.sv
// -----------------------------------------------------------------------------
// audio_source_arbiter_if
// Bundles the producer-side and audio-output-side signals of the arbiter.
//   src_req/src_valid/src_sample : producer requests, sample-valid, packed samples
//   src_grant/src_ack            : one-hot owner and per-sample take pulse
//   dac_ready/dac_wreq/dac_sample: audio output block handshake
//   busy                         : arbiter not idle
// Modports: master = producers + audio block (environment), slave = arbiter.
// -----------------------------------------------------------------------------
interface audio_source_arbiter_if
   import audio_pkg::*;
#(
   parameter int NUM_SRC    = 4,
   parameter int AUDIO_BITS = AUDIO_BITS_DEFAULT
);
   logic [NUM_SRC-1:0]              src_req;
   logic [NUM_SRC-1:0]              src_valid;
   logic [NUM_SRC*2*AUDIO_BITS-1:0] src_sample;
   logic [NUM_SRC-1:0]              src_grant;
   logic [NUM_SRC-1:0]              src_ack;
   logic                            dac_ready;
   logic                            dac_wreq;
   logic [2*AUDIO_BITS-1:0]         dac_sample;
   logic                            busy;

   modport master (
      output src_req, src_valid, src_sample, dac_ready,
      input  src_grant, src_ack, dac_wreq, dac_sample, busy
   );

   modport slave (
      input  src_req, src_valid, src_sample, dac_ready,
      output src_grant, src_ack, dac_wreq, dac_sample, busy
   );
endinterface

// File: rtl/audio_rr_pick.sv
// -----------------------------------------------------------------------------
// audio_rr_pick
// Combinational round-robin picker: finds the first set bit of req strictly
// after position last, wrapping around (last itself is searched last).
//   req      in  N    request vector
//   last     in  IW   index of the previous winner
//   pick     out N    one-hot winner (0 when no request)
//   pick_idx out IW   binary index of the winner
//   found    out 1    any request present
// -----------------------------------------------------------------------------
module audio_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  pick,
   output logic [IW-1:0] pick_idx,
   output logic          found
);

   always_comb begin
      int j;
      pick     = '0;
      pick_idx = '0;
      found    = 1'b0;
      j        = 0;
      for (int k = 1; k <= N; k++) begin
         j = int'(last) + k;
         if (j >= N) j = j - N;
         if (!found && req[j[IW-1:0]]) begin
            found              = 1'b1;
            pick[j[IW-1:0]]    = 1'b1;
            pick_idx           = j[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/audio_source_arbiter.sv
// -----------------------------------------------------------------------------
// audio_source_arbiter
// Grants the single audio output to one of NUM_SRC stereo sample producers at
// a time, round-robin, for bursts of up to BURST_LEN samples, and issues a
// one-cycle write request each time the audio output block is ready.
//   clk          in   audio PLL clock, rising edge
//   aclr         in   asynchronous reset, active high
//   bus          slave modport of audio_source_arbiter_if (producers + DAC)
//   underrun_cnt out  16-bit count of played zero-samples (only when the
//                     AUDIO_ARB_UNDERRUN_EN macro is defined)
// -----------------------------------------------------------------------------
module audio_source_arbiter
   import audio_pkg::*;
#(
   parameter int AUDIO_BITS = AUDIO_BITS_DEFAULT,
   parameter int NUM_SRC    = 4,
   parameter int BURST_LEN  = 64
) (
   input  logic                   clk,
   input  logic                   aclr,
   audio_source_arbiter_if.slave  bus
`ifdef AUDIO_ARB_UNDERRUN_EN
   ,
   output logic [UNDERRUN_W-1:0]  underrun_cnt
`endif
);

   localparam int SW = 2 * AUDIO_BITS;
   localparam int IW = idx_width(NUM_SRC);
   localparam int CW = $clog2(BURST_LEN + 1);

   arb_state_t          state_reg, state_next;
   logic [IW-1:0]       owner_reg, owner_next;
   logic [IW-1:0]       last_owner_reg, last_owner_next;
   logic [CW-1:0]       burst_cnt_reg, burst_cnt_next;
   logic [NUM_SRC-1:0]  grant_reg, grant_next;
   logic [NUM_SRC-1:0]  ack_reg, ack_next;
   logic                wreq_reg, wreq_next;
   logic [SW-1:0]       sample_reg, sample_next;

   logic [NUM_SRC-1:0]  pick_onehot;
   logic [IW-1:0]       pick_idx;
   logic                pick_found;
   logic [CW-1:0]       cnt_inc;
   logic                owner_req;
   logic                owner_valid;

   // Unpack the per-source sample slices
   logic [SW-1:0] slices [NUM_SRC];
   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slice
         assign slices[gi] = bus.src_sample[gi*SW +: SW];
      end
   endgenerate

   audio_rr_pick #(
      .N  (NUM_SRC),
      .IW (IW)
   ) u_pick (
      .req      (bus.src_req),
      .last     (last_owner_reg),
      .pick     (pick_onehot),
      .pick_idx (pick_idx),
      .found    (pick_found)
   );

   assign owner_req   = bus.src_req[owner_reg];
   assign owner_valid = bus.src_valid[owner_reg];
   assign cnt_inc     = burst_cnt_reg + 1'b1;

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         state_reg      <= IDLE;
         owner_reg      <= '0;
         last_owner_reg <= IW'(NUM_SRC - 1);   // source 0 wins first
         burst_cnt_reg  <= '0;
         grant_reg      <= '0;
         ack_reg        <= '0;
         wreq_reg       <= 1'b0;
         sample_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_owner_reg <= last_owner_next;
         burst_cnt_reg  <= burst_cnt_next;
         grant_reg      <= grant_next;
         ack_reg        <= ack_next;
         wreq_reg       <= wreq_next;
         sample_reg     <= sample_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_owner_next = last_owner_reg;
      burst_cnt_next  = burst_cnt_reg;
      grant_next      = grant_reg;
      ack_next        = '0;            // write/ack are single-cycle pulses
      wreq_next       = 1'b0;
      sample_next     = sample_reg;

      unique case (state_reg)
         IDLE: begin
            if (pick_found) begin
               grant_next     = pick_onehot;
               owner_next     = pick_idx;
               burst_cnt_next = '0;
               state_next     = OWN;
            end
         end
         OWN: begin
            if (!owner_req) begin
               // Abandoned grant: pointer is left alone, no write happens
               grant_next = '0;
               state_next = IDLE;
            end else if (bus.dac_ready && owner_valid) begin
               sample_next = slices[owner_reg];
               wreq_next   = 1'b1;
               ack_next    = grant_reg;
               state_next  = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            // Ready stays high for a cycle after the write; only its fall
            // completes the sample.
            if (!bus.dac_ready) begin
               burst_cnt_next = cnt_inc;
               if (cnt_inc == CW'(BURST_LEN) || !owner_req) begin
                  last_owner_next = owner_reg;
                  grant_next      = '0;
                  state_next      = IDLE;
               end else begin
                  state_next = OWN;
               end
            end
         end
         default: begin
            grant_next = '0;
            state_next = IDLE;
         end
      endcase
   end

   assign bus.src_grant  = grant_reg;
   assign bus.src_ack    = ack_reg;
   assign bus.dac_wreq   = wreq_reg;
   assign bus.dac_sample = sample_reg;
   assign bus.busy       = (state_reg != IDLE);

`ifdef AUDIO_ARB_UNDERRUN_EN
   // A full sample period of uninterrupted ready means the audio block
   // played a zero sample.
   logic [AUDIO_BITS-1:0] run_reg;
   logic [UNDERRUN_W-1:0] underrun_reg;

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         run_reg      <= '0;
         underrun_reg <= '0;
      end else if (!bus.dac_ready) begin
         run_reg <= '0;
      end else if (run_reg == '1) begin
         run_reg <= '0;
         if (underrun_reg != '1) underrun_reg <= underrun_reg + 1'b1;
      end else begin
         run_reg <= run_reg + 1'b1;
      end
   end

   assign underrun_cnt = underrun_reg;
`endif

endmodule
